// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
// Shared definitions for the vertical timing decoder:
//   - estado_t      : vertical FSM state encoding
//   - DEF_*         : default 640x480-style vertical timing constants
//   - lineas_totales: total lines per frame from the four line-group sizes
// No ports (package).
// -----------------------------------------------------------------------------
package vga_pkg;

  // Vertical FSM states. ESPERA waits for the first frame start after reset.
  typedef enum logic [2:0] {
    ESPERA,
    ACTIVA,
    FRENTE,
    SYNC,
    ATRAS
  } estado_t;

  localparam int DEF_CLKS_POR_LINEA  = 1600;
  localparam int DEF_LINEAS_VISIBLES = 480;
  localparam int DEF_PORCH_FRENTE    = 10;
  localparam int DEF_ANCHO_SYNC      = 2;
  localparam int DEF_PORCH_ATRAS     = 33;

  // Total lines per frame is simply the sum of the four line groups.
  function automatic int lineas_totales(input int visibles,
                                        input int frente,
                                        input int sync,
                                        input int atras);
    return visibles + frente + sync + atras;
  endfunction

  localparam int DEF_LINEAS_TOTALES = lineas_totales(DEF_LINEAS_VISIBLES,
                                                     DEF_PORCH_FRENTE,
                                                     DEF_ANCHO_SYNC,
                                                     DEF_PORCH_ATRAS);

  // Highest value the upstream frame counter reaches (525 x 1600).
  localparam int DEF_CUENTA_MAX = 840000;

endpackage

// File: rtl/contador_linea.sv
// -----------------------------------------------------------------------------
// contador_linea
// Clock-within-line counter. Counts 0..CLKS_POR_LINEA-1 while enabled and
// wraps, flagging the last clock of each line so the FSM can advance the line.
// Ports:
//   clk_i       : clock, rising edge
//   reset_i     : synchronous active-high reset
//   clear_i     : synchronous clear (frame resync), beats enable_i
//   enable_i    : count enable (low while waiting for the first frame)
//   fin_linea_o : high during the last clock of a line while enabled
// -----------------------------------------------------------------------------
module contador_linea
  import vga_pkg::*;
#(
  parameter int CLKS_POR_LINEA = DEF_CLKS_POR_LINEA
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic fin_linea_o
);

  localparam logic [10:0] ULTIMO = 11'(CLKS_POR_LINEA - 1);

  logic [10:0] clk_linea_q;
  logic [10:0] clk_linea_d;

  // Next count: a resync clear restarts the line from zero, otherwise the
  // counter steps while enabled and wraps after the last clock of the line.
  always_comb begin
    clk_linea_d = clk_linea_q;
    if (clear_i) begin
      clk_linea_d = '0;
    end else if (enable_i) begin
      clk_linea_d = (clk_linea_q == ULTIMO) ? 11'd0 : clk_linea_q + 11'd1;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      clk_linea_q <= '0;
    end else begin
      clk_linea_q <= clk_linea_d;
    end
  end

  assign fin_linea_o = enable_i && (clk_linea_q == ULTIMO);

endmodule

// File: rtl/sincronia_vertical.sv
// -----------------------------------------------------------------------------
// sincronia_vertical
// Vertical timing decoder driven by the upstream frame clock count. Produces
// the line index, active-low vertical sync, vertical display enable and a
// one-cycle start-of-frame strobe. All outputs are registered (1 cycle).
// Optional build macro: VSYNC_CHECK_EN adds the sticky error_cuenta output
// that flags any break in the count sequence (840000 -> 0 wrap is legal).
// Ports:
//   Clk           : clock, rising edge
//   Reset         : synchronous active-high reset
//   cntVertical   : 40-bit frame clock count
//   fila          : current line index
//   VSync         : vertical sync, active low
//   video_on_v    : high during active lines
//   inicio_cuadro : one-cycle pulse after a zero count is sampled
//   error_cuenta  : sticky count continuity error (VSYNC_CHECK_EN only)
// -----------------------------------------------------------------------------
module sincronia_vertical
  import vga_pkg::*;
#(
  parameter int CLKS_POR_LINEA  = DEF_CLKS_POR_LINEA,
  parameter int LINEAS_VISIBLES = DEF_LINEAS_VISIBLES,
  parameter int PORCH_FRENTE    = DEF_PORCH_FRENTE,
  parameter int ANCHO_SYNC      = DEF_ANCHO_SYNC,
  parameter int PORCH_ATRAS     = DEF_PORCH_ATRAS
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [39:0] cntVertical,
  output logic [9:0]  fila,
  output logic        VSync,
  output logic        video_on_v,
  output logic        inicio_cuadro
`ifdef VSYNC_CHECK_EN
  ,
  output logic        error_cuenta
`endif
);

  localparam int LINEAS_TOTALES = lineas_totales(LINEAS_VISIBLES, PORCH_FRENTE,
                                                 ANCHO_SYNC, PORCH_ATRAS);

  // Line numbers at which the FSM moves to the next line group.
  localparam logic [9:0] FILA_ULTIMA = 10'(LINEAS_TOTALES - 1);
  localparam logic [9:0] FILA_FRENTE = 10'(LINEAS_VISIBLES);
  localparam logic [9:0] FILA_SYNC   = 10'(LINEAS_VISIBLES + PORCH_FRENTE);
  localparam logic [9:0] FILA_ATRAS  = 10'(LINEAS_VISIBLES + PORCH_FRENTE + ANCHO_SYNC);

  estado_t    estado_q, estado_d;
  logic [9:0] fila_q, fila_d;
  logic       vsync_q, vsync_d;
  logic       video_q, video_d;
  logic       inicio_q, inicio_d;
  logic       resync;
  logic       activo;
  logic       fin_linea;

  assign resync = (cntVertical == 40'd0);
  assign activo = (estado_q != ESPERA);

  contador_linea #(
    .CLKS_POR_LINEA(CLKS_POR_LINEA)
  ) u_contador_linea (
    .clk_i      (Clk),
    .reset_i    (Reset),
    .clear_i    (resync),
    .enable_i   (activo),
    .fin_linea_o(fin_linea)
  );

  // Next-state logic. A zero count restarts the frame from any state. Else the
  // line index steps at each line end, saturating on the last line so the
  // extra clock at the frame maximum stays in ATRAS. State changes are decided
  // on the new line value so outputs line up with fila. Outputs are decoded
  // from the next state so they land in the same cycle as the state.
  always_comb begin
    estado_d = estado_q;
    fila_d   = fila_q;
    inicio_d = 1'b0;
    if (resync) begin
      estado_d = ACTIVA;
      fila_d   = '0;
      inicio_d = 1'b1;
    end else if (fin_linea) begin
      if (fila_q != FILA_ULTIMA) begin
        fila_d = fila_q + 10'd1;
      end
      if (fila_d == FILA_FRENTE) begin
        estado_d = FRENTE;
      end else if (fila_d == FILA_SYNC) begin
        estado_d = SYNC;
      end else if (fila_d == FILA_ATRAS) begin
        estado_d = ATRAS;
      end
    end
    video_d = (estado_d == ACTIVA);
    vsync_d = (estado_d != SYNC);
  end

  // State and output registers; reset drops back to waiting for a frame start.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      estado_q <= ESPERA;
      fila_q   <= '0;
      vsync_q  <= 1'b1;
      video_q  <= 1'b0;
      inicio_q <= 1'b0;
    end else begin
      estado_q <= estado_d;
      fila_q   <= fila_d;
      vsync_q  <= vsync_d;
      video_q  <= video_d;
      inicio_q <= inicio_d;
    end
  end

  assign fila          = fila_q;
  assign VSync         = vsync_q;
  assign video_on_v    = video_q;
  assign inicio_cuadro = inicio_q;

`ifdef VSYNC_CHECK_EN
  localparam logic [39:0] CUENTA_MAX = 40'(CLKS_POR_LINEA) * 40'(LINEAS_TOTALES);

  logic [39:0] cnt_prev_q;
  logic        error_q, error_d;
  logic        cuenta_ok;

  // The count must advance by exactly one, except the wrap from the frame
  // maximum back to zero. Checking only starts once a frame has been found.
  assign cuenta_ok = (cntVertical == cnt_prev_q + 40'd1) ||
                     (resync && (cnt_prev_q == CUENTA_MAX));
  assign error_d   = error_q | (activo & ~cuenta_ok);

  // Previous-count copy and sticky error flag, cleared only by reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt_prev_q <= '0;
      error_q    <= 1'b0;
    end else begin
      cnt_prev_q <= cntVertical;
      error_q    <= error_d;
    end
  end

  assign error_cuenta = error_q;
`endif

endmodule

// File: tb/tb_sincronia_vertical.sv
// -----------------------------------------------------------------------------
// tb_sincronia_vertical
// Self-checking bench for sincronia_vertical, run with a scaled-down timing
// (20 clocks/line, 12+3+2+4 lines) so whole frames fit in a short run.
// Expected values come from constant vector tables, hand-written frame
// sequences and a cycle-count based reference model.
// -----------------------------------------------------------------------------
module tb_sincronia_vertical;

  localparam int P_CLKS  = 20;
  localparam int P_VIS   = 12;
  localparam int P_FP    = 3;
  localparam int P_SW    = 2;
  localparam int P_BP    = 4;
  localparam int P_TOTAL = P_VIS + P_FP + P_SW + P_BP;
  localparam int P_MAX   = P_CLKS * P_TOTAL;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [39:0] cnt   = 40'd0;
  logic [9:0]  fila;
  logic        vSync;
  logic        videoOn;
  logic        inicio;
`ifdef VSYNC_CHECK_EN
  logic        errorCuenta;
`endif

  int nChecks = 0;
  int nFails  = 0;

  // Reference model state: whether a frame start has been seen since reset,
  // clocks elapsed since that frame start, and the continuity error.
  logic        mSync   = 1'b0;
  int          mK      = 0;
  logic        mInicio = 1'b0;
  logic        mErr    = 1'b0;
  logic [39:0] mPrev   = 40'd0;

  typedef struct {
    logic        rst;
    logic [39:0] cnt;
    logic [9:0]  fila;
    logic        vsync;
    logic        video;
    logic        inicio;
  } vector_t;

  vector_t tabla[8];

  sincronia_vertical #(
    .CLKS_POR_LINEA (P_CLKS),
    .LINEAS_VISIBLES(P_VIS),
    .PORCH_FRENTE   (P_FP),
    .ANCHO_SYNC     (P_SW),
    .PORCH_ATRAS    (P_BP)
  ) dut (
    .Clk          (clock),
    .Reset        (reset),
    .cntVertical  (cnt),
    .fila         (fila),
    .VSync        (vSync),
    .video_on_v   (videoOn),
    .inicio_cuadro(inicio)
`ifdef VSYNC_CHECK_EN
    ,
    .error_cuenta (errorCuenta)
`endif
  );

  // Free-running clock, period 10.
  always #5 clock = ~clock;

  // Safety net so the run always ends even if a loop misbehaves.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Drive one cycle of inputs, advance the model at the clock edge, and
  // return on the falling edge where outputs are sampled.
  task automatic applyStimulus(input logic r, input logic [39:0] c);
    reset = r;
    cnt   = c;
    @(posedge clock);
    if (r) begin
      mSync   = 1'b0;
      mK      = 0;
      mInicio = 1'b0;
      mErr    = 1'b0;
      mPrev   = 40'd0;
    end else begin
      if (mSync && !((c == mPrev + 40'd1) || (mPrev == 40'(P_MAX) && c == 40'd0)))
        mErr = 1'b1;
      mPrev = c;
      if (c == 40'd0) begin
        mSync   = 1'b1;
        mK      = 0;
        mInicio = 1'b1;
      end else begin
        mInicio = 1'b0;
        if (mSync) mK++;
      end
    end
    @(negedge clock);
  endtask

  task automatic checkOutput(input string name, input logic [39:0] actual,
                             input logic [39:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Expected outputs from the elapsed clocks: line = clocks / line length,
  // saturated on the last line; visible lines first, then porch, sync, porch.
  task automatic checkModel();
    int          linea;
    logic [9:0]  eFila;
    logic        eVs;
    logic        eVid;
    if (!mSync) begin
      eFila = '0;
      eVs   = 1'b1;
      eVid  = 1'b0;
    end else begin
      linea = mK / P_CLKS;
      if (linea > P_TOTAL - 1) linea = P_TOTAL - 1;
      eFila = 10'(linea);
      eVid  = (linea < P_VIS);
      eVs   = !((linea >= P_VIS + P_FP) && (linea < P_VIS + P_FP + P_SW));
    end
    checkOutput("model_fila", 40'(fila), 40'(eFila));
    checkOutput("model_vsync", 40'(vSync), 40'(eVs));
    checkOutput("model_video", 40'(videoOn), 40'(eVid));
    checkOutput("model_inicio", 40'(inicio), 40'(mInicio));
`ifdef VSYNC_CHECK_EN
    checkOutput("model_error", 40'(errorCuenta), 40'(mErr));
`endif
  endtask

  initial begin
    int          nPulsos;
    int          paso;
    int          primerPulso;
    int          segundoPulso;
    int          nBajos;
    int          primerBajo;
    int          r;
    logic        rr;
    logic [39:0] cur;

    // Reset, waiting, first frame start, reset beating a zero count.
    tabla[0] = '{1'b1, 40'd5, 10'd0, 1'b1, 1'b0, 1'b0};
    tabla[1] = '{1'b0, 40'd7, 10'd0, 1'b1, 1'b0, 1'b0};
    tabla[2] = '{1'b0, 40'd0, 10'd0, 1'b1, 1'b1, 1'b1};
    tabla[3] = '{1'b0, 40'd1, 10'd0, 1'b1, 1'b1, 1'b0};
    tabla[4] = '{1'b1, 40'd0, 10'd0, 1'b1, 1'b0, 1'b0};
    tabla[5] = '{1'b0, 40'd2, 10'd0, 1'b1, 1'b0, 1'b0};
    tabla[6] = '{1'b0, 40'd0, 10'd0, 1'b1, 1'b1, 1'b1};
    tabla[7] = '{1'b0, 40'd9, 10'd0, 1'b1, 1'b1, 1'b0};

    for (int i = 0; i < 8; i++) begin
      applyStimulus(tabla[i].rst, tabla[i].cnt);
      checkOutput("tab_fila", 40'(fila), 40'(tabla[i].fila));
      checkOutput("tab_vsync", 40'(vSync), 40'(tabla[i].vsync));
      checkOutput("tab_video", 40'(videoOn), 40'(tabla[i].video));
      checkOutput("tab_inicio", 40'(inicio), 40'(tabla[i].inicio));
    end

    // Reset for 5 cycles, then ramp from 100: nothing moves until the wrap.
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 40'd100);
    for (int c = 100; c <= P_MAX; c++) begin
      applyStimulus(1'b0, 40'(c));
      checkModel();
    end
    checkOutput("wait_fila", 40'(fila), 40'd0);
    checkOutput("wait_video", 40'(videoOn), 40'd0);

    // Two full frames starting with the wrap to zero.
    nPulsos      = 0;
    paso         = 0;
    primerPulso  = -1;
    segundoPulso = -1;
    nBajos       = 0;
    primerBajo   = -1;
    for (int f = 0; f < 2; f++) begin
      for (int c = 0; c <= P_MAX; c++) begin
        applyStimulus(1'b0, 40'(c));
        checkModel();
        if (inicio) begin
          nPulsos++;
          if (primerPulso < 0) primerPulso = paso;
          else if (segundoPulso < 0) segundoPulso = paso;
        end
        if (f == 0) begin
          if (c == 0) checkOutput("wrap_inicio", 40'(inicio), 40'd1);
          if (c == P_CLKS) checkOutput("fila_step", 40'(fila), 40'd1);
          if (c == P_VIS * P_CLKS - 1) checkOutput("video_last", 40'(videoOn), 40'd1);
          if (c == P_VIS * P_CLKS) checkOutput("video_fall", 40'(videoOn), 40'd0);
          if (!vSync) begin
            nBajos++;
            if (primerBajo < 0) primerBajo = c;
          end
          if (c == P_MAX) checkOutput("fila_at_max", 40'(fila), 40'(P_TOTAL - 1));
        end
        paso++;
      end
    end
    checkOutput("vsync_low_len", 40'(nBajos), 40'(P_SW * P_CLKS));
    checkOutput("vsync_low_start", 40'(primerBajo), 40'((P_VIS + P_FP) * P_CLKS));
    checkOutput("pulse_count", 40'(nPulsos), 40'd2);
    checkOutput("pulse_spacing", 40'(segundoPulso - primerPulso), 40'(P_MAX + 1));

    // Reset mid-frame: everything stays at rest until the next zero count.
    for (int c = 0; c <= P_MAX; c++) begin
      rr = (c >= P_MAX / 2) && (c < P_MAX / 2 + 10);
      applyStimulus(rr, 40'(c));
      checkModel();
      if (c == P_MAX / 2) checkOutput("midreset_fila", 40'(fila), 40'd0);
    end
    checkOutput("midreset_end_fila", 40'(fila), 40'd0);
    checkOutput("midreset_end_video", 40'(videoOn), 40'd0);

    // Early resync partway through a frame.
    for (int c = 0; c < 150; c++) begin
      applyStimulus(1'b0, 40'(c));
      checkModel();
    end
    checkOutput("pre_resync_fila", 40'(fila), 40'(149 / P_CLKS));
    applyStimulus(1'b0, 40'd0);
    checkModel();
    checkOutput("resync_fila", 40'(fila), 40'd0);
    checkOutput("resync_video", 40'(videoOn), 40'd1);
    checkOutput("resync_inicio", 40'(inicio), 40'd1);

`ifdef VSYNC_CHECK_EN
    // Legal wrap keeps the error clear; a skipped count sets it for good.
    applyStimulus(1'b1, 40'd0);
    applyStimulus(1'b1, 40'd0);
    for (int c = 0; c <= P_MAX; c++) applyStimulus(1'b0, 40'(c));
    for (int c = 0; c <= 51; c++) begin
      if (c == 51) begin
        checkOutput("err_legal_wrap", 40'(errorCuenta), 40'd0);
        continue;
      end
      applyStimulus(1'b0, 40'(c));
    end
    applyStimulus(1'b0, 40'd52);
    checkOutput("err_jump", 40'(errorCuenta), 40'd1);
    for (int c = 53; c <= P_MAX; c++) applyStimulus(1'b0, 40'(c));
    for (int c = 0; c < 5; c++) begin
      applyStimulus(1'b0, 40'(c));
      checkModel();
    end
    checkOutput("err_sticky", 40'(errorCuenta), 40'd1);
`endif

    // Random traffic: mostly a running count with occasional resets,
    // early resyncs and jumps.
    cur = 40'd0;
    for (int i = 0; i < 3000; i++) begin
      r  = int'($urandom_range(0, 999));
      rr = (r < 5);
      if (r >= 5 && r < 10) cur = 40'd0;
      else if (r >= 10 && r < 15) cur = 40'($urandom_range(1, P_MAX));
      else if (r >= 15 && r < 17) cur = {8'($urandom), 32'($urandom)};
      applyStimulus(rr, cur);
      checkModel();
      cur = (cur == 40'(P_MAX)) ? 40'd0 : cur + 40'd1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFails);
    $finish;
  end

endmodule
